// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy-bird game blocks: scene codes, geometry
// defaults, pipe record layout and the pipe scheduler state encoding.
package flappy_pkg;

    typedef enum logic [1:0] {
        SPLASH   = 2'd0,
        PLAYING  = 2'd1,
        GAMEOVER = 2'd2
    } scene_t;

    localparam int N_PIPE_DEF     = 3;
    localparam int GAP_LEN_DEF    = 8;
    localparam int PIPE_GAP_DEF   = 50;
    localparam int BIRD_COL_DEF   = 10;
    localparam int SCROLL_DIV_DEF = 3;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

    // One pipe record on the packed bus: {pos, max, min}.
    localparam int PIPE_W = 24;
    localparam int POS_HI = 23;
    localparam int POS_LO = 16;
    localparam int MAX_HI = 15;
    localparam int MAX_LO = 8;
    localparam int MIN_HI = 7;
    localparam int MIN_LO = 0;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_INIT = 2'd1,
        PS_RUN  = 2'd2
    } ps_state_t;

    // Bottom edge of a fresh gap; a screen no taller than the gap pins it to 0.
    function automatic logic [7:0] gap_draw(input logic [7:0] lfsr_val,
                                            input logic [7:0] n_row,
                                            input logic [7:0] gap_len);
        logic [7:0] span;
        span = n_row - gap_len;
        if (n_row <= gap_len) begin
            return 8'd0;
        end
        return lfsr_val % span;
    endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Scene-controller <-> pipe scheduler bus: control/altitude in, pipe set and
// game status out.
interface pipe_scheduler_if
    import flappy_pkg::*;
#(
    parameter int N_PIPE = N_PIPE_DEF
);
    logic                       init;
    logic                       run;
    logic [7:0]                 n_row;
    logic [7:0]                 bird_alt;
    logic [PIPE_W*N_PIPE-1:0]   pipes;
    logic                       ready;
    logic                       hit;
    logic [15:0]                score;
    logic                       recycle;

    modport master (
        output init, run, n_row, bird_alt,
        input  pipes, ready, hit, score, recycle
    );

    modport slave (
        input  init, run, n_row, bird_alt,
        output pipes, ready, hit, score, recycle
    );
endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, reloaded with seed on reset.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);
    // Right-shifting Galois form: bit i of the mask stands for x^(i+1).
    localparam logic [7:0] TAPS = 8'hB8;

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= seed;
        end else begin
            out <= {1'b0, out[7:1]} ^ (out[0] ? TAPS : 8'h00);
        end
    end
endmodule

// File: rtl/pipe_scheduler.sv
// Pipe obstacle scheduler: loads the pipe set, scrolls it at a divided rate,
// recycles the head pipe to the tail and tracks collision and score.
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int         N_PIPE     = N_PIPE_DEF,
    parameter int         SCROLL_DIV = SCROLL_DIV_DEF,
    parameter int         PIPE_GAP   = PIPE_GAP_DEF,
    parameter int         GAP_LEN    = GAP_LEN_DEF,
    parameter int         BIRD_COL   = BIRD_COL_DEF,
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_scheduler_if.slave  bus
);
    localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int K_W   = $clog2(N_PIPE + 1);

    localparam logic [7:0]       GAP_LEN_B  = 8'(GAP_LEN);
    localparam logic [7:0]       PIPE_GAP_B = 8'(PIPE_GAP);
    localparam logic [7:0]       WIN_LO     = 8'(BIRD_COL - 6);
    localparam logic [7:0]       WIN_HI     = 8'(BIRD_COL + 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCROLL_DIV - 1);
    localparam logic [K_W-1:0]   K_DONE     = K_W'(N_PIPE);

    ps_state_t          state_reg;
    logic [K_W-1:0]     k_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         pos_reg [N_PIPE];
    logic [7:0]         min_reg [N_PIPE];
    logic               ready_reg;
    logic               hit_reg;
    logic [15:0]        score_reg;
    logic               recycle_reg;

    logic [7:0]         lfsr_val;
    logic [7:0]         rnd;
    logic [7:0]         head_max;
    logic               head_in_window;
    logic               hit_cond;
    logic               step_now;
    logic               head_at_zero;
    logic               score_now;

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr_val)
    );

    assign rnd            = gap_draw(lfsr_val, bus.n_row, GAP_LEN_B);
    assign head_max       = min_reg[0] + GAP_LEN_B;
    assign head_in_window = (pos_reg[0] >= WIN_LO) && (pos_reg[0] <= WIN_HI);
    assign hit_cond       = (state_reg == PS_RUN) && head_in_window &&
                            ((bus.bird_alt <= min_reg[0]) || (bus.bird_alt >= head_max));
    assign step_now       = (state_reg == PS_RUN) && bus.run && (cnt_reg == CNT_LAST);
    assign head_at_zero   = (pos_reg[0] == 8'd0);
    // A pass only counts for a clean flight: no earlier hit and none this cycle.
    assign score_now      = step_now && !head_at_zero && (pos_reg[0] == WIN_LO) &&
                            !hit_reg && !hit_cond && (score_reg != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PS_IDLE;
            k_reg       <= '0;
            cnt_reg     <= '0;
            ready_reg   <= 1'b0;
            hit_reg     <= 1'b0;
            score_reg   <= 16'd0;
            recycle_reg <= 1'b0;
            for (int i = 0; i < N_PIPE; i++) begin
                pos_reg[i] <= 8'd0;
                min_reg[i] <= 8'd0;
            end
        end else begin
            recycle_reg <= 1'b0;
            if (bus.init) begin
                // init pre-empts everything, including a pending scroll step.
                state_reg <= PS_INIT;
                k_reg     <= '0;
                cnt_reg   <= '0;
                ready_reg <= 1'b0;
                hit_reg   <= 1'b0;
                score_reg <= 16'd0;
            end else begin
                case (state_reg)
                    PS_IDLE: begin
                    end

                    PS_INIT: begin
                        if (k_reg == K_DONE) begin
                            state_reg <= PS_RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            for (int i = 0; i < N_PIPE; i++) begin
                                if (k_reg == K_W'(i)) begin
                                    pos_reg[i] <= 8'(PIPE_GAP * (i + 1));
                                    min_reg[i] <= rnd;
                                end
                            end
                            k_reg <= k_reg + 1'b1;
                        end
                    end

                    PS_RUN: begin
                        hit_reg <= hit_reg | hit_cond;
                        if (bus.run) begin
                            if (cnt_reg == CNT_LAST) begin
                                cnt_reg <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + 1'b1;
                            end
                        end
                        if (step_now) begin
                            if (head_at_zero) begin
                                // Head has left the screen: rotate it to the tail.
                                for (int i = 0; i < N_PIPE - 1; i++) begin
                                    pos_reg[i] <= pos_reg[i+1];
                                    min_reg[i] <= min_reg[i+1];
                                end
                                pos_reg[N_PIPE-1] <= pos_reg[N_PIPE-1] + PIPE_GAP_B;
                                min_reg[N_PIPE-1] <= rnd;
                                recycle_reg       <= 1'b1;
                            end else begin
                                for (int i = 0; i < N_PIPE; i++) begin
                                    pos_reg[i] <= pos_reg[i] - 8'd1;
                                end
                                if (score_now) begin
                                    score_reg <= score_reg + 16'd1;
                                end
                            end
                        end
                    end

                    default: begin
                        state_reg <= PS_IDLE;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_PIPE; gi++) begin : g_pack
            assign bus.pipes[gi*PIPE_W + POS_LO +: 8] = pos_reg[gi];
            assign bus.pipes[gi*PIPE_W + MAX_LO +: 8] = min_reg[gi] + GAP_LEN_B;
            assign bus.pipes[gi*PIPE_W + MIN_LO +: 8] = min_reg[gi];
        end
    endgenerate

    assign bus.ready   = ready_reg;
    assign bus.hit     = hit_reg;
    assign bus.score   = score_reg;
    assign bus.recycle = recycle_reg;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: a per-cycle game model checked on every
// falling edge, plus hand-computed checkpoints along the scenario.
module tb_pipe_scheduler;
    import flappy_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_scheduler_if #(.N_PIPE(NP)) bus ();

    pipe_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: 0 idle, 1 loading, 2 running.
    int         m_mode;
    int         m_k;
    int         m_cnt;
    int         m_pos [NP];
    int         m_min [NP];
    bit         m_ready;
    bit         m_hit;
    bit         m_rec;
    int         m_score;
    logic [7:0] m_lfsr;
    bit         chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Multiply the LFSR polynomial state by x^-1 modulo x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        logic [7:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    function automatic logic [NP*24-1:0] exp_pipes();
        logic [NP*24-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) begin
            v[24*i +: 24] = {8'(m_pos[i]), 8'(m_min[i] + 8), 8'(m_min[i])};
        end
        return v;
    endfunction

    task automatic model_update();
        int  rnd;
        int  nr;
        bit  cond;
        int  alt;
        if (rst) begin
            m_mode = 0; m_k = 0; m_cnt = 0;
            for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_min[i] = 0; end
            m_ready = 0; m_hit = 0; m_score = 0; m_rec = 0;
            m_lfsr = 8'hA5;
            return;
        end
        nr  = int'(bus.n_row);
        alt = int'(bus.bird_alt);
        rnd = (nr <= 8) ? 0 : int'(m_lfsr) % (nr - 8);
        m_lfsr = lfsr_adv(m_lfsr);
        m_rec = 0;
        cond = (m_mode == 2) && (m_pos[0] >= 4) && (m_pos[0] <= 12) &&
               ((alt <= m_min[0]) || (alt >= ((m_min[0] + 8) % 256)));
        if (bus.init) begin
            m_mode = 1; m_k = 0; m_cnt = 0; m_score = 0; m_hit = 0; m_ready = 0;
        end else if (m_mode == 1) begin
            if (m_k < NP) begin
                m_pos[m_k] = 50 * (m_k + 1);
                m_min[m_k] = rnd;
                m_k++;
            end else begin
                m_mode = 2; m_ready = 1;
            end
        end else if (m_mode == 2) begin
            if (bus.run) begin
                if (m_cnt == 2) begin
                    m_cnt = 0;
                    if (m_pos[0] == 0) begin
                        for (int i = 0; i < NP - 1; i++) begin
                            m_pos[i] = m_pos[i+1];
                            m_min[i] = m_min[i+1];
                        end
                        m_pos[NP-1] = (m_pos[NP-1] + 50) % 256;
                        m_min[NP-1] = rnd;
                        m_rec = 1;
                    end else begin
                        if (m_pos[0] == 4 && !m_hit && !cond && m_score < 65535) m_score++;
                        for (int i = 0; i < NP; i++) m_pos[i] = (m_pos[i] + 255) % 256;
                    end
                end else begin
                    m_cnt++;
                end
            end
            m_hit = m_hit | cond;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Keeps the bird safely inside the head gap while cycling.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.bird_alt = 8'(m_min[0] + 4);
            cyc();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pipes",   bus.pipes,   exp_pipes());
            chk("ready",   bus.ready,   m_ready);
            chk("hit",     bus.hit,     m_hit);
            chk("score",   bus.score,   16'(m_score));
            chk("recycle", bus.recycle, m_rec);
        end
    end

    initial begin
        logic [NP*24-1:0] rst_vec;
        logic [NP*24-1:0] zero_gap_vec;
        int guard;
        int exp_head;

        rst_vec      = {3{24'h000800}};
        zero_gap_vec = {8'd150, 8'd8, 8'd0, 8'd100, 8'd8, 8'd0, 8'd50, 8'd8, 8'd0};

        rst = 1'b1;
        bus.init = 1'b0; bus.run = 1'b0; bus.n_row = 8'd40; bus.bird_alt = 8'd20;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_pipes", bus.pipes, rst_vec);
        chk("rst_ready", bus.ready, 1'b0);
        rst = 1'b0;
        cyc();

        // Load: ready rises on the fourth edge after the init pulse.
        bus.init = 1'b1; cyc(); bus.init = 1'b0;
        cyc(); cyc(); cyc();
        chk("ready_early", bus.ready, 1'b0);
        cyc();
        chk("ready_rise", bus.ready, 1'b1);
        chk("load_pos0", bus.pipes[23:16], 8'd50);
        chk("load_pos1", bus.pipes[47:40], 8'd100);
        chk("load_pos2", bus.pipes[71:64], 8'd150);
        for (int i = 0; i < NP; i++) chk("load_min_range", bus.pipes[24*i +: 8] < 8'd32, 1'b1);

        // 50 steps bring the head to 0 and score the clean pass at column 4.
        bus.run = 1'b1;
        run_cycles(150);
        chk("head_zero", bus.pipes[23:16], 8'd0);
        chk("score_one", bus.score, 16'd1);
        run_cycles(2);
        chk("recycle_wait", bus.recycle, 1'b0);
        run_cycles(1);
        chk("recycle_pulse", bus.recycle, 1'b1);
        chk("new_tail", bus.pipes[71:64], 8'd150);
        chk("new_head", bus.pipes[23:16], 8'd50);

        // Pause mid-count: nothing moves, and the phase survives the pause.
        run_cycles(1);
        bus.run = 1'b0;
        run_cycles(10);
        chk("pause_head", bus.pipes[23:16], 8'd50);
        bus.run = 1'b1;
        run_cycles(1);
        chk("phase_hold", bus.pipes[23:16], 8'd50);
        run_cycles(1);
        chk("phase_step", bus.pipes[23:16], 8'd49);

        // Collision at column 12 latches hit and blocks the next pass score.
        guard = 0;
        while (m_pos[0] != 12 && guard < 200) begin run_cycles(1); guard++; end
        chk("reach_12", bus.pipes[23:16], 8'd12);
        bus.bird_alt = 8'(m_min[0]);
        cyc();
        chk("hit_set", bus.hit, 1'b1);
        guard = 0;
        while (m_pos[0] != 3 && guard < 100) begin run_cycles(1); guard++; end
        chk("reach_3", bus.pipes[23:16], 8'd3);
        chk("hit_sticky", bus.hit, 1'b1);
        chk("score_blocked", bus.score, 16'd1);

        // init landing on a step edge wins: no step, status cleared.
        guard = 0;
        while (m_cnt != 2 && guard < 5) begin run_cycles(1); guard++; end
        exp_head = m_pos[0];
        bus.init = 1'b1; cyc(); bus.init = 1'b0;
        chk("init_no_step", bus.pipes[23:16], 8'(exp_head));
        chk("init_hit_clr", bus.hit, 1'b0);
        chk("init_score_clr", bus.score, 16'd0);
        chk("init_ready_drop", bus.ready, 1'b0);

        // Reset in the middle of a load returns to idle with everything cleared.
        cyc(); cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_init_pipes", bus.pipes, rst_vec);
        chk("rst_init_score", bus.score, 16'd0);
        cyc(); cyc();
        chk("idle_stays", bus.ready, 1'b0);

        // Screen no taller than the gap pins every gap to row 0.
        bus.run = 1'b0; bus.n_row = 8'd8;
        bus.init = 1'b1; cyc(); bus.init = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk("small_screen", bus.pipes, zero_gap_vec);
        chk("small_ready", bus.ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
